// File: rtl/matrix_stream_loader_if.sv
// Word-stream input and packed-matrix output handshakes
// for the matrix stream loader.
interface matrix_stream_loader_if #(
  parameter int DATA_W  = 16,
  parameter int N_ELEMS = 16
);
  logic [DATA_W-1:0]         s_data;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;
  logic [DATA_W*N_ELEMS-1:0] mat_out;
  logic                      mat_valid;
  logic                      mat_ack;

  modport master (
    output s_data, s_valid, s_last, mat_ack,
    input  s_ready, mat_out, mat_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, mat_ack,
    output s_ready, mat_out, mat_valid
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Packs a serial stream of 16 Q5.10 words into a 4x4 flat matrix bus,
// double-buffered with a held output released by a one-cycle ack.
module matrix_stream_loader #(
  parameter int DATA_W  = 16,
  parameter int N_ELEMS = 16,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_stream_loader_if.slave bus,
  output logic                 err_len,
  output logic [CNT_W-1:0]     frame_cnt
);
  localparam int IDX_W = $clog2(N_ELEMS);
  localparam int STG_W = DATA_W * (N_ELEMS - 1);
  localparam int MAT_W = DATA_W * N_ELEMS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEMS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [STG_W-1:0] staging;
  logic [MAT_W-1:0] mat_q;
  logic             vld_q;
  logic             at_last;
  logic             hold;
  logic             xfer;
  logic             good;

  assign at_last = (idx == LAST);
  // Final word must wait while the held matrix is still unconsumed.
  assign hold = at_last & vld_q & ~bus.mat_ack;
  assign bus.s_ready = ~rst & ((state == DRAIN) | ~hold);
  assign xfer = bus.s_valid & bus.s_ready;
  assign good = xfer & (state == FILL) & bus.s_last & at_last;

  assign bus.mat_out   = mat_q;
  assign bus.mat_valid = vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      staging   <= '0;
      mat_q     <= '0;
      vld_q     <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      err_len <= 1'b0;
      if (bus.mat_ack & vld_q & ~good)
        vld_q <= 1'b0;
      unique case (state)
        FILL: begin
          if (xfer) begin
            for (int k = 0; k < N_ELEMS - 1; k++)
              if (idx == IDX_W'(k))
                staging[k*DATA_W +: DATA_W] <= bus.s_data;
            unique case (1'b1)
              bus.s_last & ~at_last: begin
                err_len <= 1'b1;
                idx     <= '0;
              end
              ~bus.s_last & at_last: begin
                err_len <= 1'b1;
                idx     <= '0;
                state   <= DRAIN;
              end
              good: begin
                mat_q     <= {bus.s_data, staging};
                vld_q     <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
                idx       <= '0;
              end
              default: idx <= idx + 1'b1;
            endcase
          end
        end
        DRAIN: begin
          if (xfer & bus.s_last)
            state <= FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed and randomized bench for matrix_stream_loader,
// checked against a queue-based frame model.
module tb_matrix_stream_loader;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_len;
  logic [7:0] frame_cnt;

  matrix_stream_loader_if #(.DATA_W(16), .N_ELEMS(N)) bus ();

  matrix_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0]  m_q[$];
  bit           m_drop = 0;
  bit           m_valid = 0;
  bit           m_err = 0;
  logic [255:0] m_mat = '0;
  logic [7:0]   m_cnt = '0;

  bit           last_xfer = 0;
  bit           err_seen = 0;
  bit           auto_ack = 0;
  bit           gaps = 0;
  logic [15:0]  t1 [N];
  logic [255:0] a_mat;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic        xf, ak, r, lst, good, exp_rdy;
    logic [15:0] d;
    @(negedge clk);
    r   = rst;
    xf  = bus.s_valid & bus.s_ready;
    ak  = bus.mat_ack & m_valid;
    lst = bus.s_last;
    d   = bus.s_data;
    exp_rdy = !r && (m_drop ||
      !(m_q.size() == N-1 && m_valid && !bus.mat_ack));
    chk("s_ready", bus.s_ready, exp_rdy);
    last_xfer = xf;
    m_err = 0;
    good = 0;
    if (r) begin
      m_q.delete();
      m_drop  = 0;
      m_valid = 0;
      m_mat   = '0;
      m_cnt   = '0;
    end else begin
      if (xf) begin
        if (m_drop) begin
          if (lst) m_drop = 0;
        end else begin
          m_q.push_back(d);
          if (lst && m_q.size() == N) good = 1;
          else if (lst) begin
            m_err = 1;
            m_q.delete();
          end else if (m_q.size() == N) begin
            m_err  = 1;
            m_drop = 1;
            m_q.delete();
          end
        end
      end
      if (good) begin
        for (int k = 0; k < N; k++) m_mat[16*k +: 16] = m_q[k];
        m_q.delete();
        m_valid = 1;
        m_cnt++;
      end else if (ak) m_valid = 0;
    end
    @(posedge clk);
    #1;
    if (err_len) err_seen = 1;
    chk("mat_valid", bus.mat_valid, m_valid);
    chk("err_len", err_len, m_err);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("mat_out", bus.mat_out, m_mat);
    if (auto_ack) bus.mat_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(logic [15:0] d, bit last);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 0;
        cyc();
      end
    end
    bus.s_valid = 1;
    bus.s_data  = d;
    bus.s_last  = last;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!last_xfer && n < 200);
    chk("xfer_timeout", last_xfer, 1);
    bus.s_valid = 0;
    bus.s_last  = 0;
  endtask

  task automatic send_frame(int len);
    for (int i = 0; i < len; i++)
      send_word(16'($urandom), i == len - 1);
  endtask

  task automatic do_reset();
    rst = 1;
    bus.s_valid = 0;
    bus.s_last  = 0;
    bus.mat_ack = 0;
    cyc();
    cyc();
    rst = 0;
    err_seen = 0;
  endtask

  task automatic ack_once();
    bus.mat_ack = 1;
    cyc();
    bus.mat_ack = 0;
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 0;
    bus.s_last  = 0;
    bus.mat_ack = 0;
    t1 = '{16'h0400, 16'h0600, 16'h0600, 16'h0400,
           16'h0400, 16'h0600, 16'h0600, 16'h0400,
           16'h0400, 16'h0400, 16'h0600, 16'h0600,
           16'h0600, 16'h0600, 16'h0400, 16'h0600};

    do_reset();
    chk("rst_mat_out", bus.mat_out, 0);
    chk("rst_cnt", frame_cnt, 0);

    // T1
    for (int i = 0; i < N; i++) send_word(t1[i], i == N-1);
    chk("t1_valid", bus.mat_valid, 1);
    chk("t1_e0", bus.mat_out[15:0], 16'h0400);
    chk("t1_e4", bus.mat_out[79:64], t1[4]);
    chk("t1_e15", bus.mat_out[255:240], 16'h0600);
    chk("t1_cnt", frame_cnt, 1);
    ack_once();
    chk("t1_acked", bus.mat_valid, 0);

    // T2
    send_frame(5);
    chk("t2_valid", bus.mat_valid, 0);
    send_frame(N);
    chk("t2_good", bus.mat_valid, 1);
    chk("t2_cnt", frame_cnt, 2);
    ack_once();

    // T3
    do_reset();
    send_frame(20);
    chk("t3_err", err_seen, 1);
    chk("t3_valid", bus.mat_valid, 0);
    send_frame(N);
    chk("t3_cnt", frame_cnt, 1);
    ack_once();

    // T4
    do_reset();
    send_frame(N);
    a_mat = m_mat;
    for (int i = 0; i < N-1; i++) send_word(16'($urandom), 0);
    bus.s_valid = 1;
    bus.s_data  = 16'($urandom);
    bus.s_last  = 1;
    repeat (3) cyc();
    chk("t4_stall", last_xfer, 0);
    chk("t4_hold_a", bus.mat_out, a_mat);
    bus.mat_ack = 1;
    cyc();
    chk("t4_b_xfer", last_xfer, 1);
    bus.mat_ack = 0;
    bus.s_valid = 0;
    bus.s_last  = 0;
    chk("t4_valid", bus.mat_valid, 1);
    chk("t4_cnt", frame_cnt, 2);
    cyc();

    // T5
    for (int i = 0; i < 7; i++) send_word(16'($urandom), 0);
    do_reset();
    chk("t5_mat_zero", bus.mat_out, 0);
    send_frame(N);
    chk("t5_no_err", err_seen, 0);
    chk("t5_cnt", frame_cnt, 1);

    // T6
    do_reset();
    auto_ack = 1;
    gaps = 1;
    for (int f = 0; f < 256; f++) send_frame(N);
    chk("t6_wrap", frame_cnt, 0);
    auto_ack = 0;
    gaps = 0;
    bus.mat_ack = 1;
    cyc();
    bus.mat_ack = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
